fsm_ij_driver: RTL
==================

Name: fsm_ij_driver

Overview:
- Synthesizable stimulus/response engine for the fsm_prob_b two-input FSM (inputs i,j; Moore outputs x,y).
- Software-side logic loads a script of {ij, expected xy} vectors into an internal FIFO and pulses start.
- The block then drives i,j one vector per clock, samples x,y at the correct pipeline point, compares them against the expected values, and reports error count, first-failure index and done.
- It is the driving/checking end of the same i,j → x,y interface, used for on-chip self-test of the FSM.

Parameters:
- DEPTH, 8: number of vector entries in the FIFO (power of two, ≥2).
- CNT_W, $clog2(DEPTH+1): width of the counters and index outputs.

Ports:
- clk  input  1  system clock, all state on posedge
- rstn  input  1  asynchronous active-low reset
- wr_en  input  1  push one vector; accepted only in IDLE and when not full
- wr_ij  input  2  vector stimulus {i,j}
- wr_exp  input  2  expected {x,y} response to that vector
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- overflow  output  1  sticky: wr_en seen while full or while not IDLE
- start  input  1  begin run; accepted only in IDLE with FIFO non-empty
- i  output  1  stimulus to DUT (registered)
- j  output  1  stimulus to DUT (registered)
- x  input  1  DUT response
- y  input  1  DUT response
- busy  output  1  state is RUN or DRAIN
- done  output  1  run completed; cleared on next accepted start
- err_cnt  output  CNT_W  mismatches in the last run; saturates at all-ones
- first_err_idx  output  CNT_W  0-based index of the first mismatching vector; valid when err_cnt≠0
- first_err_xy  output  2  {x,y} actually observed at first_err_idx

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; FIFO emptied (pointers and count = 0).
  - i=j=0, full=0, empty=1, overflow=0, busy=0, done=0.
  - err_cnt=0, first_err_idx=0, first_err_xy=0.
  - Pipeline valid bits v1=v2=0.
  - Reset mid-run aborts the run with no partial result retained.
- FIFO:
  - Circular, DEPTH entries of {ij, exp}, pointer wrap at DEPTH.
  - Count tracks 0..DEPTH.
  - Push only in IDLE && !full.
  - A rejected push sets overflow; overflow clears only on reset.
- States:
  - IDLE:
    - start && !empty → RUN, and the same edge clears err_cnt, done and the vector index.
    - start while empty is ignored.
    - wr_en and start in the same cycle: the push takes effect and start is evaluated against the pre-push count. An empty FIFO therefore ignores that start.
  - RUN:
    - Each edge pops one entry and registers {i,j}=entry.ij.
    - The same edge loads stage1: exp_s1=entry.exp, v1=1, idx_s1=index, then increments index.
    - The edge that pops the last entry moves to DRAIN.
  - DRAIN:
    - No pop; v1 loads 0.
    - i,j hold the last applied value.
    - → IDLE on the edge where both v1 and v2 are 0 after the update. This gives 2 cycles after the last pop.
    - The same edge sets done=1.
- Check pipeline (matches the DUT's registered state):
  - Vector n is driven after edge E_n, and the DUT updates at E_n+1.
  - Every edge moves stage1 to stage2 (exp_s2, v2, idx_s2).
  - At each edge with v2=1, compare {x,y} with exp_s2, so vector n is checked at E_n+2.
  - On mismatch, err_cnt increments with saturation.
  - If err_cnt was 0 before the mismatch, also capture first_err_idx=idx_s2 and first_err_xy={x,y}.
- Latency for N vectors: busy for N+2 cycles from the accepting edge; done asserts at edge N+2.
- i,j keep their last value in IDLE.
- start during RUN/DRAIN is ignored.
- wr_en during RUN/DRAIN is rejected and sets overflow.

Test Plan:
1. Reset FSM and driver together. Load 8 vectors {ij,exp}: (11,01),(10,10),(01,10),(01,10),(00,10),(10,10),(00,11),(00,11). Pulse start. Expected: full=1 before start; busy for 10 cycles; done=1; err_cnt=0; i,j trace the script one per cycle; i,j finally =00.
2. Same script with vector 3's expected value changed to 01. Expected: err_cnt=1, first_err_idx=3, first_err_xy=10.
3. Corrupt the expected values of vectors 1 and 5. Expected: err_cnt=2; first_err_idx=1 (second error does not overwrite the capture).
4. Write 9 vectors with DEPTH=8. Expected: the 9th is rejected, overflow=1, count=8. Pulse start with an empty FIFO after a drained run. Expected: state stays IDLE, done unchanged.
5. Load 4 vectors, start, and deassert rstn during the 2nd RUN cycle. Expected: i=j=0, busy=0, done=0, empty=1, err_cnt=0 immediately (asynchronously).
6. Load a single vector (11,01). Expected: busy exactly 3 cycles, check occurs at E+2, done=1, err_cnt=0. Then write a new vector and start again. Expected: err_cnt and done cleared at that accept edge.

Source files
------------

// File: rtl/fsm_ij_driver.sv
// fsm_ij_driver: scripted stimulus/response engine for a two-input Moore FSM.
// A FIFO of {ij, expected xy} vectors is replayed one per clock on i,j, and
// the FSM's x,y are checked two edges later against the expected values.
module fsm_ij_driver #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [1:0]       wr_ij,
    input  logic [1:0]       wr_exp,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             start,
    output logic             i,
    output logic             j,
    input  logic             x,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       first_err_xy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    // Each entry is {ij, exp}; pointers wrap naturally because DEPTH is 2^PTR_W.
    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       head;

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_s1;
    logic [CNT_W-1:0] idx_s2;
    logic [1:0]       exp_s1;
    logic [1:0]       exp_s2;
    logic             v1;
    logic             v2;

    logic push;
    logic pop;
    logic accept;
    logic last_pop;
    logic drain_done;
    logic mismatch;

    assign head       = mem[rd_ptr];
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign busy       = (state != IDLE);
    assign push       = wr_en && (state == IDLE) && !full;
    assign accept     = start && (state == IDLE) && !empty;
    assign pop        = (state == RUN);
    assign last_pop   = pop && (count == ONE_CNT);
    assign drain_done = (state == DRAIN) && !v1;
    assign mismatch   = v2 && ({x, y} != exp_s2);

    // State register; an asynchronous reset aborts any run in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start is judged on the pre-push count, DRAIN waits for the
    // check pipeline to empty before returning to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = RUN;
            RUN:     if (last_pop)   state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Vector storage; contents need no reset since the count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_ij, wr_exp};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag for rejected pushes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + ONE_CNT;
            end else if (pop && !push) begin
                count <= count - ONE_CNT;
            end
            if (wr_en && (full || (state != IDLE))) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stimulus outputs and stage 1: pop a vector, drive it, remember its expectation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i      <= 1'b0;
            j      <= 1'b0;
            v1     <= 1'b0;
            exp_s1 <= '0;
            idx_s1 <= '0;
            idx    <= '0;
        end else begin
            v1 <= pop;
            if (pop) begin
                {i, j} <= head[3:2];
                exp_s1 <= head[1:0];
                idx_s1 <= idx;
            end
            if (accept) begin
                idx <= '0;
            end else if (pop) begin
                idx <= idx + ONE_CNT;
            end
        end
    end

    // Stage 2 lines up with the edge at which the FSM's response to a vector is visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2     <= 1'b0;
            exp_s2 <= '0;
            idx_s2 <= '0;
        end else begin
            v2     <= v1;
            exp_s2 <= exp_s1;
            idx_s2 <= idx_s1;
        end
    end

    // Result registers: saturating error count, first-failure capture and done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_xy  <= '0;
            done          <= 1'b0;
        end else begin
            if (accept) begin
                err_cnt <= '0;
                done    <= 1'b0;
            end else begin
                if (mismatch) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ONE_CNT;
                    end
                    if (err_cnt == '0) begin
                        first_err_idx <= idx_s2;
                        first_err_xy  <= {x, y};
                    end
                end
                if (drain_done) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
